// File: rtl/rv32i_types.sv
// Shared RV32I core types: data word, branch-predictor counter states, update request.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    strong_nt = 2'b00,
    weak_nt   = 2'b01,
    weak_t    = 2'b10,
    strong_t  = 2'b11
  } bht_state_t;

  localparam bht_state_t BHT_RESET = weak_nt;

  // One resolved-branch write into the predictor tables.
  typedef struct packed {
    logic      en;
    logic      taken;
    rv32i_word target;
  } bht_upd_t;

  // 2-bit saturating counter step: up on taken, down on not-taken.
  function automatic bht_state_t bht_next(input bht_state_t s, input logic taken);
    bht_state_t n;
    n = s;
    case (s)
      strong_nt: n = taken ? weak_nt  : strong_nt;
      weak_nt:   n = taken ? weak_t   : strong_nt;
      weak_t:    n = taken ? strong_t : weak_nt;
      strong_t:  n = taken ? strong_t : weak_t;
      default:   n = BHT_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bht_array.sv
// Branch history counters, valid bits and tagless target storage for the predictor.
// Latency: read is combinational (no write bypass); write lands at the clock edge.
// Backpressure: none; the caller gates the write enable.
module bht_array
  import rv32i_types::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  output rv32i_word        rd_target,
  input  logic [IDX_W-1:0] wr_idx,
  input  bht_upd_t         upd
);

  bht_state_t ctr   [ENTRIES];
  logic       valid [ENTRIES];
  rv32i_word  tgt   [ENTRIES];

  // Counters and valid bits: reset to weak-not-taken/invalid, then saturating update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i]   <= BHT_RESET;
        valid[i] <= 1'b0;
      end
    end else if (upd.en) begin
      ctr[wr_idx] <= bht_next(ctr[wr_idx], upd.taken);
      if (upd.taken) begin
        valid[wr_idx] <= 1'b1;
      end
    end
  end

  // Targets carry no reset: contents are masked by valid until the first taken write.
  always_ff @(posedge clk) begin
    if (rst_n && upd.en && upd.taken) begin
      tgt[wr_idx] <= upd.target;
    end
  end

  // Taken prediction needs a valid entry with the counter's upper bit set.
  assign rd_taken  = valid[rd_idx] & ctr[rd_idx][1];
  assign rd_target = tgt[rd_idx];

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: mispredict detect, one-cycle redirect, stats, predictor update.
// Latency: prediction 0 cycles; redirect registered, high exactly one cycle after resolve.
// Backpressure: stall freezes all updates; resolve is masked while redirect is high.
module branch_resolve
  import rv32i_types::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  rv32i_word if_pc,
  output logic      if_pred_taken,
  output rv32i_word if_pred_target,
  input  logic      ex_valid,
  input  logic      ex_is_branch,
  input  rv32i_word ex_pc,
  input  rv32i_word ex_target,
  input  logic      ex_taken,
  input  logic      ex_pred_taken,
  input  rv32i_word ex_pred_target,
  input  logic      stall,
  output logic      redirect,
  output rv32i_word redirect_pc,
  output rv32i_word branch_count,
  output rv32i_word mispredict_count
);

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             resolve;
  logic             mispredict;
  rv32i_word        corrected_pc;
  bht_upd_t         upd;
  logic             unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // The ~redirect term drops the wrong-path instruction sitting in EX during the flush.
  assign resolve    = ex_valid & ex_is_branch & ~stall & ~redirect;
  assign mispredict = (ex_taken != ex_pred_taken) |
                      (ex_taken & ex_pred_taken & (ex_pred_target != ex_target));
  assign corrected_pc = ex_taken ? ex_target : (ex_pc + 32'd4);

  assign upd.en     = resolve;
  assign upd.taken  = ex_taken;
  assign upd.target = ex_target;

  // Bits outside the index field never address the table.
  assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], ex_pc[31:IDX_W+2], ex_pc[1:0]};

  bht_array #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (if_idx),
    .rd_taken  (if_pred_taken),
    .rd_target (if_pred_target),
    .wr_idx    (ex_idx),
    .upd       (upd)
  );

  // Redirect pulse, corrected PC and wrapping statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect         <= 1'b0;
      redirect_pc      <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      redirect <= resolve & mispredict;
      if (resolve & mispredict) begin
        redirect_pc <= corrected_pc;
      end
      if (resolve) begin
        branch_count <= branch_count + 32'd1;
        if (mispredict) begin
          mispredict_count <= mispredict_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a reference predictor model and redirect scoreboard.
// Latency: expects redirect one cycle after a mispredicting resolve.
// Backpressure: exercises stall and the redirect shadow cycle.
module tb_branch_resolve;
  import rv32i_types::*;

  logic      clk;
  logic      rst_n;
  rv32i_word if_pc;
  logic      if_pred_taken;
  rv32i_word if_pred_target;
  logic      ex_valid;
  logic      ex_is_branch;
  rv32i_word ex_pc;
  rv32i_word ex_target;
  logic      ex_taken;
  logic      ex_pred_taken;
  rv32i_word ex_pred_target;
  logic      stall;
  logic      redirect;
  rv32i_word redirect_pc;
  rv32i_word branch_count;
  rv32i_word mispredict_count;

  branch_resolve dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .if_pred_target   (if_pred_target),
    .ex_valid         (ex_valid),
    .ex_is_branch     (ex_is_branch),
    .ex_pc            (ex_pc),
    .ex_target        (ex_target),
    .ex_taken         (ex_taken),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic      redir;
    rv32i_word pc;
  } exp_t;

  exp_t      sb[$];
  int        checks;
  int        errors;
  int        mctr [64];
  bit        mval [64];
  rv32i_word mtgt [64];
  logic      model_redir;
  rv32i_word mbc;
  rv32i_word mmc;

  task automatic chk(input string tag, input rv32i_word obs, input rv32i_word exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mctr[i] = 1;
      mval[i] = 1'b0;
    end
    model_redir = 1'b0;
    mbc = '0;
    mmc = '0;
  endtask

  task automatic lookup(input string tag, input rv32i_word pc);
    int i;
    if_pc = pc;
    #1;
    i = int'(pc[7:2]);
    chk(tag, {31'b0, if_pred_taken}, {31'b0, (mval[i] && mctr[i] >= 2) ? 1'b1 : 1'b0});
    if (mval[i]) chk({tag, "_tgt"}, if_pred_target, mtgt[i]);
  endtask

  // One EX cycle: drive at negedge, predict expected results, compare after the edge.
  task automatic cycle(input string tag, input logic v, input logic br, input rv32i_word pc,
                       input rv32i_word tgt, input logic tk, input logic ptk,
                       input rv32i_word ptgt, input logic stl);
    int   i;
    logic res;
    logic mis;
    exp_t e;
    @(negedge clk);
    ex_valid = v; ex_is_branch = br; ex_pc = pc; ex_target = tgt;
    ex_taken = tk; ex_pred_taken = ptk; ex_pred_target = ptgt; stall = stl;
    if_pc = pc;
    #1;
    i = int'(pc[7:2]);
    chk({tag, "_pre_pred"}, {31'b0, if_pred_taken},
        {31'b0, (mval[i] && mctr[i] >= 2) ? 1'b1 : 1'b0});
    res = v && br && !stl && !model_redir;
    mis = (tk != ptk) || (tk && ptk && (ptgt != tgt));
    if (res) begin
      mbc = mbc + 32'd1;
      if (mis) mmc = mmc + 32'd1;
      if (tk) begin
        mctr[i] = (mctr[i] == 3) ? 3 : mctr[i] + 1;
        mval[i] = 1'b1;
        mtgt[i] = tgt;
      end else begin
        mctr[i] = (mctr[i] == 0) ? 0 : mctr[i] - 1;
      end
    end
    model_redir = res && mis;
    e.redir = model_redir;
    e.pc    = tk ? tgt : pc + 32'd4;
    sb.push_back(e);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    stall    = 1'b0;
    e = sb.pop_front();
    chk({tag, "_redirect"}, {31'b0, redirect}, {31'b0, e.redir});
    if (e.redir) chk({tag, "_redirect_pc"}, redirect_pc, e.pc);
    chk({tag, "_branch_count"}, branch_count, mbc);
    chk({tag, "_mispredict_count"}, mispredict_count, mmc);
  endtask

  task automatic idle();
    cycle("idle", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    if_pc = '0;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = '0; ex_target = '0;
    ex_taken = 1'b0; ex_pred_taken = 1'b0; ex_pred_target = '0; stall = 1'b0;
    model_reset();

    // Reset state and cold lookup.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_redirect", {31'b0, redirect}, 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    chk("reset_branch_count", branch_count, 32'd0);
    chk("reset_mispredict_count", mispredict_count, 32'd0);
    lookup("reset_lookup_100", 32'h100);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Cold taken branch: mispredict to 0x80, entry becomes valid and taken.
    cycle("cold", 1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("cold_rpc_lit", redirect_pc, 32'h80);
    idle();
    lookup("cold_lookup", 32'h100);

    // Saturation: three more correct takens, then not-taken twice.
    for (int k = 0; k < 3; k++) begin
      cycle("sat_taken", 1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 1'b1, 32'h80, 1'b0);
    end
    cycle("sat_nt1", 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 1'b1, 32'h80, 1'b0);
    idle();
    lookup("sat_after_nt1", 32'h100);
    chk("sat_after_nt1_lit", {31'b0, if_pred_taken}, 32'd1);
    cycle("sat_nt2", 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 1'b0, 32'h80, 1'b0);
    lookup("sat_after_nt2", 32'h100);

    // Target mismatch: predicted 0x80, actual 0xC0.
    cycle("tgt_mis", 1'b1, 1'b1, 32'h100, 32'hC0, 1'b1, 1'b1, 32'h80, 1'b0);
    chk("tgt_mis_rpc_lit", redirect_pc, 32'hC0);
    idle();
    lookup("tgt_mis_lookup", 32'h100);

    // Not-taken mispredict at the top of the address space wraps to zero.
    cycle("wrap", 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h40, 1'b0, 1'b1, 32'h40, 1'b0);
    chk("wrap_rpc_lit", redirect_pc, 32'h0);
    idle();
    lookup("wrap_lookup", 32'hFFFF_FFFC);

    // Shadow: a branch in EX during the redirect cycle is ignored.
    cycle("shadow_mis", 1'b1, 1'b1, 32'h204, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle("shadow_br", 1'b1, 1'b1, 32'h208, 32'h400, 1'b1, 1'b0, 32'h0, 1'b0);
    lookup("shadow_lookup", 32'h208);

    // Stall holds the event; it resolves once stall drops.
    cycle("stall_hold", 1'b1, 1'b1, 32'h20C, 32'h500, 1'b1, 1'b1, 32'h500, 1'b1);
    lookup("stall_lookup", 32'h20C);
    cycle("stall_go", 1'b1, 1'b1, 32'h20C, 32'h500, 1'b1, 1'b1, 32'h500, 1'b0);
    lookup("stall_go_lookup", 32'h20C);

    // Non-branch and invalid slots have no effect.
    cycle("nonbranch", 1'b1, 1'b0, 32'h210, 32'h600, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle("invalid", 1'b0, 1'b1, 32'h214, 32'h700, 1'b1, 1'b0, 32'h0, 1'b0);
    lookup("nonbranch_lookup", 32'h210);

    // Reset mid-operation drops the redirect and the update.
    @(negedge clk);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h218; ex_target = 32'h800;
    ex_taken = 1'b1; ex_pred_taken = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    ex_valid = 1'b0;
    chk("midrst_redirect", {31'b0, redirect}, 32'd0);
    chk("midrst_branch_count", branch_count, 32'd0);
    chk("midrst_mispredict_count", mispredict_count, 32'd0);
    lookup("midrst_lookup_218", 32'h218);
    lookup("midrst_lookup_100", 32'h100);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
